// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant and a
// mandatory one-cycle idle turnaround between consecutive grants.
module rr_arbiter8 #(
    parameter logic [3:0] MAX_HOLD = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   hcnt;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   cand;
    logic            sel_found;
    logic            release_c;

    // First set request bit at or after ptr, wrapping modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = ptr;
        for (int i = 0; i < N; i++) begin
            cand = IW'(ptr + IW'(i));
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign release_c = !req[grant_idx] || !en || (hcnt == MAX_HOLD - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant       <= 8'h00;
            grant_idx   <= '0;
            ptr         <= '0;
            hcnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && sel_found) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        grant_idx   <= sel_idx;
                        grant       <= 8'b1 << sel_idx;
                        hcnt        <= '0;
                    end
                end
                GRANT: begin
                    // Releasing always passes through IDLE, which gives the turnaround cycle.
                    if (release_c) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        grant       <= 8'h00;
                        ptr         <= IW'(grant_idx + 3'd1);
                    end
                    hcnt <= CW'(hcnt + 4'd1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed vector table, corner-case
// sequences, and random traffic against a cycle-level reference model.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] g8, g1;
    logic [2:0] i8, i1;
    logic       v8, v1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(4'd8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(g8), .grant_idx(i8), .grant_valid(v8)
    );

    rr_arbiter8 #(.MAX_HOLD(4'd1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(g1), .grant_idx(i1), .grant_valid(v1)
    );

    // Reference: busy flag, who holds it, next-priority requester, cycles held so far.
    typedef struct {
        bit busy;
        int idx;
        int ptr;
        int held;
    } mdl_t;

    mdl_t m8, m1;

    function automatic mdl_t step(mdl_t m, bit r, bit e, logic [7:0] rq, int mh);
        mdl_t n = m;
        if (r) begin
            n.busy = 0; n.idx = 0; n.ptr = 0; n.held = 0;
        end else if (!m.busy) begin
            if (e && rq != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int j = (m.ptr + k) % 8;
                    if (rq[j]) begin
                        n.idx = j;
                        break;
                    end
                end
                n.busy = 1;
                n.held = 1;
            end
        end else begin
            if (!rq[m.idx] || !e || m.held == mh) begin
                n.busy = 0;
                n.ptr  = (m.idx + 1) % 8;
            end else begin
                n.held = m.held + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] mgrant(mdl_t m);
        return m.busy ? 8'(1 << m.idx) : 8'h00;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        m8 = step(m8, rst, en, req, 8);
        m1 = step(m1, rst, en, req, 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] req;
        logic [7:0] g;
        logic [2:0] idx;
        bit         v;
    } vec_t;

    vec_t vecs[12];

    initial begin
        m8 = '{0, 0, 0, 0};
        m1 = '{0, 0, 0, 0};

        // Priority/wrap, enable drop and reset recovery on the MAX_HOLD=8 instance.
        vecs[0]  = '{1, 0, 8'h00, 8'h00, 3'd0, 0};
        vecs[1]  = '{0, 1, 8'h81, 8'h01, 3'd0, 1};
        vecs[2]  = '{0, 1, 8'h80, 8'h00, 3'd0, 0};
        vecs[3]  = '{0, 1, 8'h80, 8'h80, 3'd7, 1};
        vecs[4]  = '{0, 1, 8'h00, 8'h00, 3'd7, 0};
        vecs[5]  = '{0, 1, 8'h81, 8'h01, 3'd0, 1};
        vecs[6]  = '{0, 0, 8'h81, 8'h00, 3'd0, 0};
        vecs[7]  = '{0, 0, 8'hFF, 8'h00, 3'd0, 0};
        vecs[8]  = '{0, 0, 8'hFF, 8'h00, 3'd0, 0};
        vecs[9]  = '{0, 1, 8'hFF, 8'h02, 3'd1, 1};
        vecs[10] = '{1, 1, 8'hFF, 8'h00, 3'd0, 0};
        vecs[11] = '{0, 1, 8'h11, 8'h01, 3'd0, 1};

        #2;
        for (int t = 0; t < 12; t++) begin
            rst = vecs[t].rst;
            en  = vecs[t].en;
            req = vecs[t].req;
            tick();
            check($sformatf("vec%0d_grant", t), g8, vecs[t].g);
            check($sformatf("vec%0d_idx", t), 8'(i8), 8'(vecs[t].idx));
            check($sformatf("vec%0d_valid", t), 8'(v8), 8'(vecs[t].v));
        end

        // Hold limit: 8 cycles per grant, one idle cycle between.
        rst = 1; tick();
        rst = 0; en = 1; req = 8'h06;
        for (int k = 0; k < 19; k++) begin
            logic [7:0] exp;
            tick();
            if (k < 8)       exp = 8'h02;
            else if (k == 8) exp = 8'h00;
            else if (k < 17) exp = 8'h04;
            else if (k == 17) exp = 8'h00;
            else             exp = 8'h02;
            check($sformatf("hold_k%0d", k), g8, exp);
        end

        // Full fairness with MAX_HOLD=1.
        rst = 1; tick();
        rst = 0; en = 1; req = 8'hFF;
        for (int k = 0; k < 17; k++) begin
            tick();
            check($sformatf("fair_k%0d", k), g1,
                  (k % 2 == 0) ? 8'(1 << ((k / 2) % 8)) : 8'h00);
        end

        // Reset during a grant does not advance the pointer.
        rst = 1; tick();
        rst = 0; en = 1; req = 8'h10; tick();
        check("rstmid_grant", g8, 8'h10);
        rst = 1; tick();
        check("rstmid_drop", g8, 8'h00);
        rst = 0; req = 8'h11; tick();
        check("rstmid_regrant", g8, 8'h01);

        // Random traffic against the model; requests tend to persist so holds occur.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(63) == 0);
            en  = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) req = 8'($urandom);
            else if ($urandom_range(7) == 0) req = req & 8'($urandom);
            tick();
            check("rand_g8", g8, mgrant(m8));
            check("rand_v8", 8'(v8), 8'(m8.busy));
            check("rand_i8", 8'(i8), 8'(m8.idx));
            check("rand_g1", g1, mgrant(m1));
            check("rand_v1", 8'(v1), 8'(m1.busy));
            check("rand_i1", 8'(i1), 8'(m1.idx));
            check("rand_onehot8", 8'($onehot0(g8)), 8'd1);
            check("rand_onehot1", 8'($onehot0(g1)), 8'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 4'd8, is the maximum number of consecutive cycles a single grant may be held. Legal range is 1..15.
REQ-002 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  is the reset: synchronous and active-high.
REQ-004 en  input  1  is the arbitration enable; when low, no new grant is issued and any held grant is released.
REQ-005 req  input  8  holds one request bit per requester; bit i belongs to requester i.
REQ-006 grant  output  8  is the one-hot grant vector; all zeros when no grant is held.
REQ-007 grant_idx  output  3  is the binary index of the granted requester; valid only while grant_valid=1.
REQ-008 grant_valid  output  1  is high while a grant is held.

Function
REQ-009 The block SHALL have two states: IDLE and GRANT.
REQ-010 grant SHALL be the 3-to-8 decode of grant_idx gated by grant_valid, so that grant[k]=grant_valid & (grant_idx==k).
REQ-011 The block SHALL keep a 3-bit round-robin pointer ptr; ptr is the highest-priority requester in the next arbitration.
REQ-012 IDLE behaviour: if en=1 and req!=0, the block SHALL select the first set req bit scanning ptr, ptr+1, ... mod 8.
  - grant_idx loads the selected index.
  - grant_valid goes to 1 and the state moves to GRANT on the same edge.
  - Latency from request to grant is 1 cycle.
REQ-013 IDLE with en=0 or req=0: the block SHALL stay in IDLE with grant_valid=0.
REQ-014 The block SHALL use a 4-bit hold counter hcnt, cleared to 0 on entry to GRANT and incremented by 1 on each cycle spent in GRANT.
REQ-015 GRANT behaviour: the grant SHALL release on the next edge if any of the following holds:
  - req[grant_idx]=0;
  - en=0;
  - hcnt==MAX_HOLD-1.
  Otherwise the grant SHALL be held unchanged.
REQ-016 On release, the block SHALL:
  - set grant_valid to 0;
  - set ptr to grant_idx+1 mod 8, so 7 wraps to 0;
  - return to IDLE.
REQ-017 After every release, the block SHALL spend at least one cycle in IDLE (grant all zeros) before any new grant, even if requests are pending; this is a one-cycle turnaround.
REQ-018 Requests from other requesters during GRANT SHALL NOT affect the held grant or ptr.
REQ-019 In IDLE, the pointer and selection SHALL use the current req value only; requests are not latched.
REQ-020 grant SHALL never have more than one bit set in any cycle.
REQ-021 grant_idx SHALL hold its last value while in IDLE; consumers use grant_valid to qualify it.
REQ-022 With MAX_HOLD=1, every grant SHALL last exactly one cycle.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL set state=IDLE, grant_valid=0, grant=8'h00, grant_idx=3'd0, ptr=3'd0 and hcnt=4'd0.
REQ-024 rst SHALL take priority over all other inputs, including during GRANT; a held grant drops on the reset edge without updating ptr beyond the reset value.
REQ-025 In the first cycle after rst deasserts, the block SHALL be in IDLE and SHALL issue a grant on the following edge if en=1 and req!=0.

Verification
REQ-026 Reset then priority: reset, then en=1, req=8'h81 -> next cycle grant=8'h01, idx=0; drop req[0] -> grant=8'h00 for one cycle, then grant=8'h80, idx=7; ptr wraps to 0 after release.
REQ-027 Hold limit: MAX_HOLD=8, req=8'h06 held constant -> grant=8'h02 for exactly 8 cycles, 1 idle cycle, grant=8'h04 for 8 cycles, 1 idle cycle, grant=8'h02.
REQ-028 Full fairness: req=8'hFF constant, MAX_HOLD=1 -> grants cycle 01,02,04,...,80,01 with one zero cycle between each.
REQ-029 Enable drop: en deasserted mid-grant -> grant=8'h00 next edge; with en held low and req!=0, grant stays 8'h00.
REQ-030 Reset mid-grant: rst asserted while grant=8'h10 -> grant=8'h00 next edge; after release with req=8'h11 -> grant=8'h01 (ptr=0, not 5).
REQ-031 Randomized check: random req/en streams -> grant is always one-hot or zero and matches decode(grant_idx) when valid.
